io_serdes_host: RTL and testbench
=================================

Name: io_serdes_host

Overview:
Host-side initiator for the byte-serial operand/result interface of the io_serdes block. Accepts a 32-bit operand pair A/B over a valid/ready command port and streams the 8 bytes MSB-first onto the 8-bit bus. It then raises start_calc, waits a programmable time, and raises output_result. It collects the 4 returned result bytes into Z and presents Z on a valid/ready result port. Used in benches and in on-chip self-test to drive the serdes and its datapath.

Parameters:
CALC_WAIT, 4, cycles start_calc is held high before output_result rises (legal range 1..255)
RX_LATENCY, 1, cycles from the output_result rise to the first valid result byte on bus_in (legal range 0..15)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  operand pair offered
cmd_ready  out  1  host can accept a command; high only in IDLE
op_a  in  32  operand A; captured on the handshake
op_b  in  32  operand B; captured on the handshake
bus_out  out  8  byte stream to the serdes inputs
bus_in  in  8  byte stream from the serdes outputs
start_calc  out  1  level request to start the calculation
output_result  out  1  level request to stream out the result
res_valid  out  1  res_z valid
res_ready  in  1  result consumer ready
res_z  out  32  collected result
busy  out  1  high in every state except IDLE
txn_count  out  16  completed-transaction count; see Optional Feature

Behaviour:
- Reset (asynchronous, any time, including mid-transaction): state=IDLE, bus_out=0, start_calc=0, output_result=0, res_valid=0, res_z=0, busy=0, cmd_ready=1, all counters=0, txn_count=0.
- FSM states: IDLE, SEND, CALC, COLLECT, DONE.
- IDLE
  - cmd_ready=1 and bus_out=0.
  - Handshake at edge N (cmd_valid & cmd_ready) latches {op_a,op_b} into a 64-bit shift register and moves to SEND.
- SEND
  - Lasts 8 cycles, N+1..N+8.
  - bus_out = A[31:24], A[23:16], A[15:8], A[7:0], B[31:24], B[23:16], B[15:8], B[7:0].
  - Each byte is driven from a register, so it is stable for the whole cycle.
  - After the 8th byte, go to CALC. bus_out returns to 0.
- CALC
  - start_calc=1 from cycle N+9. It stays high through CALC and COLLECT.
  - After CALC_WAIT cycles in CALC, go to COLLECT.
- COLLECT
  - output_result=1 for the whole state.
  - Let the first COLLECT cycle be index 0. bus_in is sampled at the end of cycles RX_LATENCY..RX_LATENCY+3.
  - Bytes shift into res_z MSB-first: the first sampled byte becomes res_z[31:24].
  - After the 4th sample, go to DONE.
- DONE
  - start_calc=0, output_result=0, res_valid=1, res_z held stable.
  - res_valid & res_ready at an edge: go to IDLE and clear res_valid.
  - res_valid never drops without res_ready.
- Back-pressure: if res_ready is high on the first DONE cycle, DONE lasts exactly 1 cycle. A new command is accepted no earlier than the cycle after DONE.
- Minimum transaction length: 8 + CALC_WAIT + RX_LATENCY + 4 + 1 cycles from the handshake to res_valid falling. With the defaults this is 18.
- cmd_valid while busy is ignored, and the operand inputs are not sampled.
- Internal counters are sized to cover the parameter ranges. They never wrap within a state.

Optional Feature:
Macro IO_SERDES_HOST_CNT_EN.
- Defined: txn_count increments by 1 on each DONE->IDLE transition. It wraps from 16'hFFFF to 0 and is cleared only by reset.
- Not defined: txn_count is tied to 16'h0000 and no counter logic is built.
- The port exists in both builds.

Test Plan:
- Reset held, then released; check outputs every cycle -> all outputs at their reset values; cmd_ready=1, busy=0.
- op_a=32'hDEADBEEF, op_b=32'hABCDEF12, handshake at edge N -> bus_out in cycles N+1..N+8 = DE AD BE EF AB CD EF 12; start_calc rises at N+9; output_result rises at N+13 (CALC_WAIT=4).
- Loopback model returns AB FF 78 92 starting RX_LATENCY=1 cycle after output_result rises -> res_valid=1 with res_z=32'hABFF7892; res_ready=1 -> back to IDLE in 1 cycle.
- Same transaction with res_ready held low for 5 cycles -> res_valid and res_z hold stable for all 5 cycles; a cmd_valid pulse during DONE is not accepted (cmd_ready=0).
- Assert reset during the third SEND byte -> bus_out=0, start_calc=0, state IDLE immediately; a following transaction with op_a=32'h01234567 completes normally.
- With IO_SERDES_HOST_CNT_EN defined, run 3 transactions -> txn_count=3. Without the macro, run the same 3 -> txn_count=0.

Source files
------------

// File: rtl/io_serdes_host.sv
// io_serdes_host: byte-serial operand/result initiator for io_serdes; IO_SERDES_HOST_CNT_EN builds txn_count
module io_serdes_host #(
   parameter int CALC_WAIT  = 4,
   parameter int RX_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic [7:0]  bus_out,
   input  logic [7:0]  bus_in,
   output logic        start_calc,
   output logic        output_result,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_z,
   output logic        busy,
   output logic [15:0] txn_count
);
   typedef enum logic [2:0] {IDLE, SEND, CALC, COLLECT, DONE} state_t;
   state_t      state_q, state_d;
   logic [63:0] sh_q, sh_d;
   logic [7:0]  bus_q, bus_d, cnt_q, cnt_d;
   logic [31:0] z_q, z_d;
   // state and datapath registers
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         sh_q    <= '0;
         bus_q   <= '0;
         cnt_q   <= '0;
         z_q     <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         bus_q   <= bus_d;
         cnt_q   <= cnt_d;
         z_q     <= z_d;
      end
   // next-state: bus byte is pre-loaded one edge ahead so bus_out comes straight from bus_q
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      bus_d   = bus_q;
      cnt_d   = cnt_q;
      z_d     = z_q;
      case (state_q)
         IDLE:
            if (cmd_valid) begin
               state_d = SEND;
               sh_d    = {op_a[23:0], op_b, 8'h00};
               bus_d   = op_a[31:24];
               cnt_d   = '0;
            end
         SEND:
            if (cnt_q == 8'd7) begin
               state_d = CALC;
               bus_d   = '0;
               cnt_d   = '0;
            end else begin
               bus_d = sh_q[63:56];
               sh_d  = {sh_q[55:0], 8'h00};
               cnt_d = cnt_q + 8'd1;
            end
         CALC:
            if (cnt_q == 8'(CALC_WAIT - 1)) begin
               state_d = COLLECT;
               cnt_d   = '0;
            end else cnt_d = cnt_q + 8'd1;
         COLLECT: begin
            z_d = (cnt_q >= 8'(RX_LATENCY)) ? {z_q[23:0], bus_in} : z_q;
            if (cnt_q == 8'(RX_LATENCY + 3)) begin
               state_d = DONE;
               cnt_d   = '0;
            end else cnt_d = cnt_q + 8'd1;
         end
         DONE:    state_d = res_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   assign cmd_ready     = (state_q == IDLE);
   assign busy          = (state_q != IDLE);
   assign start_calc    = (state_q == CALC) || (state_q == COLLECT);
   assign output_result = (state_q == COLLECT);
   assign res_valid     = (state_q == DONE);
   assign res_z         = z_q;
   assign bus_out       = bus_q;
`ifdef IO_SERDES_HOST_CNT_EN
   logic [15:0] txn_q;
   // completed transactions, counted on DONE->IDLE
   always_ff @(posedge clk or posedge reset)
      if (reset) txn_q <= '0;
      else if (state_q == DONE && res_ready) txn_q <= txn_q + 16'd1;
   assign txn_count = txn_q;
`else
   assign txn_count = 16'h0000;
`endif
endmodule

// File: tb/tb_io_serdes_host.sv
// tb_io_serdes_host: directed scoreboard bench for io_serdes_host
module tb_io_serdes_host;
   localparam int CW = 4;
   localparam int RL = 1;
   logic        clk = 0, reset = 1, cmd_valid = 0, res_ready = 0;
   logic [31:0] op_a = 0, op_b = 0;
   logic [7:0]  bus_in = 0;
   logic        cmd_ready, start_calc, output_result, res_valid, busy;
   logic [7:0]  bus_out;
   logic [31:0] res_z;
   logic [15:0] txn_count;
   int          checks = 0, failures = 0, done = 0;
   logic [7:0]  bq[$];
   logic [31:0] zq[$];

   io_serdes_host #(.CALC_WAIT(CW), .RX_LATENCY(RL)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .op_a(op_a), .op_b(op_b), .bus_out(bus_out), .bus_in(bus_in),
      .start_calc(start_calc), .output_result(output_result), .res_valid(res_valid),
      .res_ready(res_ready), .res_z(res_z), .busy(busy), .txn_count(txn_count));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_bus_out"}, bus_out, 0);
      chk({tag, "_start_calc"}, start_calc, 0);
      chk({tag, "_output_result"}, output_result, 0);
      chk({tag, "_res_valid"}, res_valid, 0);
      chk({tag, "_cmd_ready"}, cmd_ready, 1);
      chk({tag, "_busy"}, busy, 0);
   endtask

   task automatic chk_cnt();
`ifdef IO_SERDES_HOST_CNT_EN
      chk("txn_count", txn_count, 64'(done));
`else
      chk("txn_count", txn_count, 0);
`endif
   endtask

   task automatic txn(input logic [31:0] a, input logic [31:0] b, input logic [31:0] z, input int hold);
      logic [63:0] ab;
      logic [31:0] zb;
      ab = {a, b};
      zb = z;
      for (int i = 0; i < 8; i++) bq.push_back(ab[63-8*i -: 8]);
      zq.push_back(z);
      res_ready = (hold == 0);
      @(negedge clk);
      chk("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1; op_a = a; op_b = b;
      @(negedge clk);
      cmd_valid = 0; op_a = ~a; op_b = ~b;
      for (int i = 0; i < 8; i++) begin
         chk("bus_out_send", bus_out, bq.pop_front());
         chk("start_calc_send", start_calc, 0);
         chk("busy_send", busy, 1);
         @(negedge clk);
      end
      chk("bus_out_calc", bus_out, 0);
      for (int i = 0; i < CW; i++) begin
         chk("start_calc_calc", start_calc, 1);
         chk("output_result_calc", output_result, 0);
         @(negedge clk);
      end
      chk("output_result_rise", output_result, 1);
      for (int i = 0; i < RL + 4; i++) begin
         chk("start_calc_collect", start_calc, 1);
         bus_in = (i >= RL) ? zb[31-8*(i-RL) -: 8] : 8'h5A;
         @(negedge clk);
      end
      bus_in = 8'hA5;
      chk("res_valid_done", res_valid, 1);
      chk("res_z_done", res_z, zq.pop_front());
      chk("start_calc_done", start_calc, 0);
      chk("output_result_done", output_result, 0);
      chk("cmd_ready_done", cmd_ready, 0);
      for (int k = 0; k < hold; k++) begin
         chk("res_valid_hold", res_valid, 1);
         chk("res_z_hold", res_z, z);
         cmd_valid = (k == 1);
         if (k == 1) chk("cmd_ready_hold", cmd_ready, 0);
         @(negedge clk);
      end
      cmd_valid = 0;
      res_ready = 1;
      @(negedge clk);
      done++;
      chk_idle("after_done");
      chk_cnt();
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk_idle("reset");
         chk("reset_res_z", res_z, 0);
         chk_cnt();
      end
      reset = 0;
      @(negedge clk);
      chk_idle("post_reset");
      txn(32'hDEADBEEF, 32'hABCDEF12, 32'hABFF7892, 0);
      txn(32'hDEADBEEF, 32'hABCDEF12, 32'hABFF7892, 5);
      txn(32'h13579BDF, 32'h2468ACE0, 32'hCAFEF00D, 0);
      res_ready = 1;
      @(negedge clk);
      cmd_valid = 1; op_a = 32'hDEADBEEF; op_b = 32'hABCDEF12;
      @(negedge clk);
      cmd_valid = 0;
      chk("abort_byte0", bus_out, 8'hDE);
      @(negedge clk);
      chk("abort_byte1", bus_out, 8'hAD);
      @(negedge clk);
      chk("abort_byte2", bus_out, 8'hBE);
      reset = 1;
      #1;
      chk_idle("mid_reset");
      done = 0;
      chk_cnt();
      @(negedge clk);
      reset = 0;
      txn(32'h01234567, 32'h89ABCDEF, 32'h0F1E2D3C, 0);
      txn(32'hFFFFFFFF, 32'h00000000, 32'h80000001, 2);
      txn(32'h00000000, 32'hFFFFFFFF, 32'h00FF00FF, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
